// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR address sequencer.
// Holds the FSM state encoding, parameter defaults and the modular
// subtract used to walk the circular sample buffer backwards.
package fir_pkg;

  localparam int TAPS_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int LAT_DEF  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    CALC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // (a - b) mod m for a, b < m; avoids a divider for non-power-of-two m.
  function automatic int unsigned wrap_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned m);
    if (a >= b) begin
      return a - b;
    end
    return a + m - b;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// LAT-deep 1-bit shift register aligning mac_en with the index-register output.
// Latency: exactly LAT cycles (LAT = 0 is a wire).
// Backpressure: none; shifts every cycle, cleared asynchronously by rst.
module fir_delay_line #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (LAT == 0) begin : g_pass
      assign q = d;
    end else begin : g_sr
      logic [LAT-1:0] sr;

      // Shift ld in at bit 0; the oldest sample leaves at the top bit.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sr <= '0;
        end else begin
          sr <= (sr << 1) | LAT'(d);
        end
      end

      assign q = sr[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fir_addr_seq.sv
// FIR control sequencer: writes one sample, then walks all taps driving ld/rd_addr/coef_addr and aligned MAC control.
// Latency: out_valid rises TAPS+2+LAT cycles after the input handshake.
// Backpressure: in_ready only in IDLE; out_valid holds in DONE until out_ready.
module fir_addr_seq
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = AW_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          ld,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [AW-1:0] TAP_LAST   = AW'(TAPS - 1);
  localparam logic [1:0]    DRAIN_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] tap;
  logic [1:0]    drain_cnt;
  logic [AW-1:0] rd_hold;
  logic [AW-1:0] rd_cur;

  // Newest sample sits at wptr; tap k reads the sample k steps older.
  assign rd_cur = AW'(wrap_sub(32'(wptr), 32'(tap), 32'(TAPS)));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tap, drain and write-pointer counters plus the held read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      tap       <= '0;
      drain_cnt <= '0;
      rd_hold   <= '0;
    end else begin
      case (state)
        WRITE: begin
          tap <= '0;
        end
        CALC: begin
          rd_hold   <= rd_cur;
          drain_cnt <= '0;
          tap       <= (tap == TAP_LAST) ? '0 : tap + 1'b1;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            wptr <= (wptr == TAP_LAST) ? '0 : wptr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and Moore output decode; in_ready is the only rst-gated term.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    ld        = 1'b0;
    rd_addr   = rd_hold;
    coef_addr = '0;
    mac_clr   = 1'b0;
    out_valid = 1'b0;

    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        wr_en     = 1'b1;
        wr_addr   = wptr;
        mac_clr   = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        ld        = 1'b1;
        rd_addr   = rd_cur;
        coef_addr = tap;
        if (tap == TAP_LAST) begin
          state_nxt = (LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  fir_delay_line #(
    .LAT(LAT)
  ) u_delay (
    .clk(clk),
    .rst(rst),
    .d  (ld),
    .q  (mac_en)
  );

endmodule

// File: tb/tb_fir_addr_seq.sv
// Directed bench for fir_addr_seq: one default instance (TAPS=32, LAT=1)
// and one TAPS=20, LAT=0 instance, selected onto shared probe signals.
module tb_fir_addr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;
  logic out_ready;
  logic sel;

  int n_cmp = 0;
  int n_err = 0;

  logic       iv0, or0, in_ready0, wr_en0, ld0, mac_clr0, mac_en0, out_valid0;
  logic [4:0] wr_addr0, rd_addr0, coef_addr0;
  logic       iv1, or1, in_ready1, wr_en1, ld1, mac_clr1, mac_en1, out_valid1;
  logic [4:0] wr_addr1, rd_addr1, coef_addr1;

  logic       o_in_ready, o_wr_en, o_ld, o_mac_clr, o_mac_en, o_out_valid;
  logic [4:0] o_wr_addr, o_rd_addr, o_coef_addr;

  assign iv0 = in_valid & ~sel;
  assign or0 = out_ready & ~sel;
  assign iv1 = in_valid & sel;
  assign or1 = out_ready & sel;

  always_comb begin
    o_in_ready  = sel ? in_ready1  : in_ready0;
    o_wr_en     = sel ? wr_en1     : wr_en0;
    o_ld        = sel ? ld1        : ld0;
    o_mac_clr   = sel ? mac_clr1   : mac_clr0;
    o_mac_en    = sel ? mac_en1    : mac_en0;
    o_out_valid = sel ? out_valid1 : out_valid0;
    o_wr_addr   = sel ? wr_addr1   : wr_addr0;
    o_rd_addr   = sel ? rd_addr1   : rd_addr0;
    o_coef_addr = sel ? coef_addr1 : coef_addr0;
  end

  fir_addr_seq dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .ld(ld0), .rd_addr(rd_addr0),
    .coef_addr(coef_addr0), .mac_clr(mac_clr0), .mac_en(mac_en0),
    .out_valid(out_valid0), .out_ready(or0)
  );

  fir_addr_seq #(.TAPS(20), .AW(5), .LAT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .ld(ld1), .rd_addr(rd_addr1),
    .coef_addr(coef_addr1), .mac_clr(mac_clr1), .mac_en(mac_en1),
    .out_valid(out_valid1), .out_ready(or1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  o_in_ready,  0);
    chk({tag, "_wr_en"},     o_wr_en,     0);
    chk({tag, "_wr_addr"},   o_wr_addr,   0);
    chk({tag, "_ld"},        o_ld,        0);
    chk({tag, "_rd_addr"},   o_rd_addr,   0);
    chk({tag, "_coef_addr"}, o_coef_addr, 0);
    chk({tag, "_mac_clr"},   o_mac_clr,   0);
    chk({tag, "_mac_en"},    o_mac_en,    0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
  endtask

  // One transaction starting at a negedge in IDLE. Cycle c counts from the
  // cycle after the accepting edge. abort_tap >= 0 resets mid-CALC at that tap.
  task automatic run_txn(input int T, input int L, input int w,
                         input int hold, input bit early, input int abort_tap);
    int n_mac;
    bit ld_exp;
    n_mac = 0;
    chk("idle_in_ready", o_in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (early) out_ready = 1'b1;
    for (int c = 1; c < T + 2 + L; c++) begin
      if (abort_tap >= 0 && c == abort_tap + 2) begin
        chk("pre_abort_coef", o_coef_addr, abort_tap);
        chk("pre_abort_ld", o_ld, 1);
        rst = 1'b0;
        in_valid = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        chk_all_zero("abort_hold");
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_rel_in_ready", o_in_ready, 1);
        repeat (3) begin
          @(negedge clk);
          chk("abort_rel_mac_en", o_mac_en, 0);
          chk("abort_rel_wr_en", o_wr_en, 0);
          chk("abort_rel_in_ready", o_in_ready, 1);
        end
        out_ready = 1'b0;
        return;
      end
      ld_exp = (c >= 2 && c <= T + 1);
      chk("wr_en", o_wr_en, (c == 1));
      chk("mac_clr", o_mac_clr, (c == 1));
      if (c == 1) chk("wr_addr", o_wr_addr, w);
      chk("ld", o_ld, ld_exp);
      if (ld_exp) begin
        chk("coef_addr", o_coef_addr, c - 2);
        chk("rd_addr", o_rd_addr, (w - (c - 2) + T) % T);
      end
      chk("mac_en", o_mac_en, (c >= 2 + L && c <= T + 1 + L));
      chk("busy_out_valid", o_out_valid, 0);
      chk("busy_in_ready", o_in_ready, 0);
      if (o_mac_en) n_mac++;
      @(negedge clk);
    end
    chk("mac_en_count", n_mac, T);
    chk("rd_addr_held", o_rd_addr, (w + 1) % T);
    for (int h = 0; h < hold; h++) begin
      chk("bp_out_valid", o_out_valid, 1);
      chk("bp_in_ready", o_in_ready, 0);
      chk("bp_wr_en", o_wr_en, 0);
      in_valid = h[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("done_out_valid", o_out_valid, 1);
    chk("done_mac_en", o_mac_en, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_out_valid", o_out_valid, 0);
    chk("after_in_ready", o_in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    sel       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    sel = 1'b1;
    #1;
    chk_all_zero("reset_b");
    sel = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("release_in_ready", o_in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("release_wr_en", o_wr_en, 0);
      chk("release_in_ready", o_in_ready, 1);
    end

    // First sample with 10 cycles of output backpressure.
    run_txn(32, 1, 0, 10, 1'b0, -1);
    // Back-to-back: wptr 1..31, then the wrap to 0 and on to 5.
    for (int i = 1; i < 32; i++) run_txn(32, 1, i, 0, 1'b1, -1);
    for (int i = 0; i <= 5; i++) run_txn(32, 1, i, 0, 1'b0, -1);
    // Abort at tap 10, then a clean transaction from wptr 0.
    run_txn(32, 1, 6, 0, 1'b0, 10);
    run_txn(32, 1, 0, 0, 1'b0, -1);

    // TAPS=20, LAT=0 instance: full pointer cycle and wrap back to 0.
    sel = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) run_txn(20, 0, i, 0, i[0], -1);
    run_txn(20, 0, 0, 2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_addr_seq.md
Name: fir_addr_seq

Overview:
- Control sequencer directly upstream of the FIR sample-index register.
- Accepts one input sample per transaction through a valid/ready handshake, writes it into the circular sample buffer, then steps through all taps.
- For each tap it drives the index register's load strobe and 5-bit address, the coefficient address, and aligned MAC control.
- Signals result-ready to the output stage and holds until that stage accepts.

Parameters:
- TAPS, 32, number of filter taps. Legal range: 2 to 2^AW. Non-power-of-two values are supported.
- AW, 5, address width. Matches the index register's address width.
- LAT, 1, cycles between ld and valid MAC operands. 0 to 3 legal. Default covers the index-register stage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  new sample present.
- in_ready  out  1  block can accept a sample.
- wr_en  out  1  sample-buffer write strobe.
- wr_addr  out  AW  sample-buffer write address (write pointer).
- ld  out  1  load strobe to the index register.
- rd_addr  out  AW  sample address presented to the index register input.
- coef_addr  out  AW  coefficient ROM address (tap index).
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate enable, already aligned by LAT.
- out_valid  out  1  filter result valid.
- out_ready  in  1  downstream accepts result.

Behaviour:
- rst low forces, immediately:
  - state IDLE, wptr 0, tap 0, mac_en delay line 0.
  - every output 0, including in_ready, which is gated by rst.
- All outputs except in_ready are Moore decodes of registered state, counters or the delay line. There is no input-to-output combinational path.
- FSM states: IDLE, WRITE, CALC, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready at a rising edge moves to WRITE. That cycle is "cycle 0".
- WRITE (cycle 1):
  - wr_en = 1, wr_addr = wptr, mac_clr = 1.
  - Next state CALC, tap = 0.
- CALC (cycles 2 .. TAPS+1):
  - ld = 1, coef_addr = tap, rd_addr = (wptr - tap) mod TAPS.
  - When wptr < tap, rd_addr = wptr - tap + TAPS.
  - tap increments each cycle. After tap = TAPS-1, go to DRAIN, or to DONE if LAT = 0.
- mac_en is ld delayed exactly LAT cycles. It is high for exactly TAPS consecutive cycles per transaction.
- DRAIN (LAT cycles): ld = 0, and the delay line empties. Then go to DONE.
- DONE (from cycle TAPS+2+LAT):
  - out_valid = 1, held until out_ready.
  - On out_valid & out_ready: wptr <= (wptr = TAPS-1) ? 0 : wptr+1, then IDLE on the next cycle.
- in_valid outside IDLE is ignored, so there is no sample loss as long as the source obeys the handshake.
- out_ready asserted early is harmless. DONE lasts one cycle if out_ready is already high.
- Reset mid-transaction:
  - Abort at once and clear the delay line, so no stray mac_en appears after release.
  - wptr returns to 0.
  - Buffer contents are not cleared; treating them as stale is a system-level decision.
- All outputs other than ld and rd_addr are 0 in states where this spec does not define them. rd_addr holds its last value when ld = 0.

Decomposition:
- Shared package fir_pkg holds:
  - state enum.
  - defaults for TAPS, AW, LAT.
  - a wrap-subtract helper function for rd_addr.
- One sub-module, fir_delay_line: a LAT-deep 1-bit shift register with async active-low clear. It produces mac_en from ld.

Test Plan:
- Reset: hold rst low with in_valid = 1 -> all outputs 0, in_ready 0. Release -> in_ready 1 in the first cycle; no write until a handshake occurs.
- Single sample, TAPS=32, LAT=1, wptr=0, accepted in cycle 0:
  - wr_en and mac_clr in cycle 1, wr_addr 0.
  - ld in cycles 2..33, rd_addr 0,31,30,…,1, coef_addr 0..31.
  - mac_en in cycles 3..34, out_valid in cycle 35.
- Backpressure: hold out_ready low 10 cycles after out_valid -> out_valid stays 1, in_ready stays 0, in_valid pulses are ignored, wptr does not change. Raising out_ready -> IDLE one cycle later.
- Wrap, TAPS=32: 32 back-to-back transactions -> the 33rd uses wr_addr 0. A transaction at wptr=5 gives rd_addr 5,4,…,0,31,…,6.
- Reset at tap 10 of CALC -> ld, mac_en and all outputs drop immediately, with no mac_en after release. The next transaction writes wr_addr 0 and produces exactly 32 mac_en cycles.
- TAPS=20, LAT=0:
  - wptr=3 gives rd_addr 3,2,1,0,19,…,4.
  - mac_en coincides with ld, out_valid in cycle 22.
  - wptr wraps from 19 to 0.
